dmem_port_arbiter: RTL and testbench

- Shares the single-port data SRAM between two requesters: port 0 is the memory stage load/store path, and port 1 is the instruction-fetch/debug loader path.
- Grants at most one access per cycle and drives the SRAM port.
- Tracks in-flight reads through a latency pipeline and routes read data back to the requester that issued the read.
- Sits between the pipeline stages and the SRAM macro, replacing their direct SRAM connections.

---
 rtl/dmem_port_arbiter.sv | 144 ++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_port_arbiter.sv
// Two-port arbiter in front of the single-port data SRAM, with read-response routing.
// Optional macro DMEM_ARB_ROUND_ROBIN_EN switches contention from fixed port-0 priority to round-robin.
module dmem_port_arbiter #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    p0_req_valid,
    output logic                    p0_req_ready,
    input  logic                    p0_req_write,
    input  logic [ADDR_WIDTH-1:0]   p0_req_addr,
    input  logic [DATA_WIDTH-1:0]   p0_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] p0_req_be,
    output logic                    p0_rsp_valid,
    output logic [DATA_WIDTH-1:0]   p0_rsp_rdata,

    input  logic                    p1_req_valid,
    output logic                    p1_req_ready,
    input  logic                    p1_req_write,
    input  logic [ADDR_WIDTH-1:0]   p1_req_addr,
    input  logic [DATA_WIDTH-1:0]   p1_req_wdata,
    input  logic [DATA_WIDTH/8-1:0] p1_req_be,
    output logic                    p1_rsp_valid,
    output logic [DATA_WIDTH-1:0]   p1_rsp_rdata,

    output logic                    mem_enable,
    output logic                    mem_write_enable,
    output logic [ADDR_WIDTH-1:0]   mem_address,
    output logic [DATA_WIDTH-1:0]   mem_write_data,
    output logic [DATA_WIDTH/8-1:0] mem_byte_enable,
    input  logic [DATA_WIDTH-1:0]   mem_read_data
);

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_e;

    logic  grant_valid;
    port_e grant_port;

    // Read-tracking pipeline: one {valid, port} entry per SRAM latency stage.
    logic [READ_LATENCY-1:0] pipe_valid_q, pipe_valid_d;
    logic [READ_LATENCY-1:0] pipe_port_q,  pipe_port_d;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    port_e last_grant_q, last_grant_d;
`endif

    // Grant is purely combinational; holding it low in reset keeps the SRAM idle.
    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        grant_valid = 1'b0;
        grant_port  = PORT0;
        if (rst) begin
            if (p0_req_valid && p1_req_valid) begin
                grant_valid = 1'b1;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                grant_port  = (last_grant_q == PORT1) ? PORT0 : PORT1;
`else
                grant_port  = PORT0;
`endif
            end else if (p0_req_valid) begin
                grant_valid = 1'b1;
                grant_port  = PORT0;
            end else if (p1_req_valid) begin
                grant_valid = 1'b1;
                grant_port  = PORT1;
            end
        end
    end

    assign p0_req_ready = grant_valid && (grant_port == PORT0);
    assign p1_req_ready = grant_valid && (grant_port == PORT1);

    always_comb begin
        mem_enable       = 1'b0;
        mem_write_enable = 1'b0;
        mem_address      = '0;
        mem_write_data   = '0;
        mem_byte_enable  = '0;
        if (p0_req_ready) begin
            mem_enable       = 1'b1;
            mem_write_enable = p0_req_write;
            mem_address      = p0_req_addr;
            mem_write_data   = p0_req_wdata;
            mem_byte_enable  = p0_req_be;
        end else if (p1_req_ready) begin
            mem_enable       = 1'b1;
            mem_write_enable = p1_req_write;
            mem_address      = p1_req_addr;
            mem_write_data   = p1_req_wdata;
            mem_byte_enable  = p1_req_be;
        end
    end

    // Stage 0 takes the new read (writes insert a bubble); older stages shift toward the output.
    always_comb begin
        pipe_valid_d    = '0;
        pipe_port_d     = '0;
        pipe_valid_d[0] = grant_valid && !mem_write_enable;
        pipe_port_d[0]  = grant_port;
        for (int i = 1; i < READ_LATENCY; i++) begin
            pipe_valid_d[i] = pipe_valid_q[i-1];
            pipe_port_d[i]  = pipe_port_q[i-1];
        end
    end

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        last_grant_d = last_grant_q;
        if (grant_valid) begin
            last_grant_d = grant_port;
        end
    end
`endif

    // Async clear drops every in-flight read, so late SRAM data is never forwarded.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pipe_valid_q <= '0;
            pipe_port_q  <= '0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last_grant_q <= PORT1;
`endif
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            pipe_valid_q <= pipe_valid_d;
            pipe_port_q  <= pipe_port_d;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign p0_rsp_valid = pipe_valid_q[READ_LATENCY-1] && (pipe_port_q[READ_LATENCY-1] == PORT0);
    assign p1_rsp_valid = pipe_valid_q[READ_LATENCY-1] && (pipe_port_q[READ_LATENCY-1] == PORT1);
    assign p0_rsp_rdata = p0_rsp_valid ? mem_read_data : '0;
    assign p1_rsp_rdata = p1_rsp_valid ? mem_read_data : '0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter: three instances at READ_LATENCY 1, 2 and 3 share stimulus,
// each with its own SRAM model. Expectations follow DMEM_ARB_ROUND_ROBIN_EN when defined.
module tb_dmem_port_arbiter;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk;
    logic rst;

    logic        p0_v, p0_w, p1_v, p1_w;
    logic [31:0] p0_a, p0_d, p1_a, p1_d;
    logic [3:0]  p0_be, p1_be;

    logic        p0_rdy [3];
    logic        p1_rdy [3];
    logic        p0_rv  [3];
    logic        p1_rv  [3];
    logic [31:0] p0_rd  [3];
    logic [31:0] p1_rd  [3];
    logic        mem_en [3];
    logic        mem_we [3];
    logic [31:0] mem_addr  [3];
    logic [31:0] mem_wdata [3];
    logic [31:0] mem_rdata [3];
    logic [3:0]  mem_be    [3];

    logic [31:0] sram    [3][256];
    bit          written [3][256];
    logic [31:0] rd_pipe [3][4];

    int n_checks = 0;
    int n_errors = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_port_arbiter #(
            .ADDR_WIDTH  (32),
            .DATA_WIDTH  (32),
            .READ_LATENCY(g + 1)
        ) u_dut (
            .clk             (clk),
            .rst             (rst),
            .p0_req_valid    (p0_v),
            .p0_req_ready    (p0_rdy[g]),
            .p0_req_write    (p0_w),
            .p0_req_addr     (p0_a),
            .p0_req_wdata    (p0_d),
            .p0_req_be       (p0_be),
            .p0_rsp_valid    (p0_rv[g]),
            .p0_rsp_rdata    (p0_rd[g]),
            .p1_req_valid    (p1_v),
            .p1_req_ready    (p1_rdy[g]),
            .p1_req_write    (p1_w),
            .p1_req_addr     (p1_a),
            .p1_req_wdata    (p1_d),
            .p1_req_be       (p1_be),
            .p1_rsp_valid    (p1_rv[g]),
            .p1_rsp_rdata    (p1_rd[g]),
            .mem_enable      (mem_en[g]),
            .mem_write_enable(mem_we[g]),
            .mem_address     (mem_addr[g]),
            .mem_write_data  (mem_wdata[g]),
            .mem_byte_enable (mem_be[g]),
            .mem_read_data   (mem_rdata[g])
        );
        assign mem_rdata[g] = rd_pipe[g][g];
    end

    function automatic logic [31:0] init_val(input logic [7:0] idx);
        case (idx)
            8'h10:   return 32'hDEADBEEF;
            8'h11:   return 32'h0BADF00D;
            8'h40:   return 32'h12345678;
            8'h80:   return 32'hFFFFFFFF;
            8'h81:   return 32'h0000CAFE;
            default: return {24'h5A0000, idx};
        endcase
    endfunction

    function automatic logic [31:0] rd_word(input int k, input logic [7:0] idx);
        return written[k][idx] ? sram[k][idx] : init_val(idx);
    endfunction

    // SRAM models: word-indexed, byte-enabled writes, read data delayed by each instance's latency.
    always @(posedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (mem_en[k] && mem_we[k]) begin
                logic [31:0] w;
                w = rd_word(k, mem_addr[k][9:2]);
                for (int b = 0; b < 4; b++)
                    if (mem_be[k][b]) w[8*b +: 8] = mem_wdata[k][8*b +: 8];
                sram[k][mem_addr[k][9:2]]    <= w;
                written[k][mem_addr[k][9:2]] <= 1'b1;
            end
            rd_pipe[k][0] <= (mem_en[k] && !mem_we[k]) ? rd_word(k, mem_addr[k][9:2]) : 32'h0;
            for (int j = 1; j < 4; j++) rd_pipe[k][j] <= rd_pipe[k][j-1];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic set_p0(input logic v, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be);
        p0_v = v; p0_w = w; p0_a = a; p0_d = d; p0_be = be;
    endtask

    task automatic set_p1(input logic v, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic [3:0] be);
        p1_v = v; p1_w = w; p1_a = a; p1_d = d; p1_be = be;
    endtask

    task automatic idle();
        set_p0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_p1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            idle();
        end
    endtask

    logic exp_p0, prev_p0;

    initial begin
        rst = 1'b0;
        idle();

        // Reset held with a pending request: nothing is granted, nothing driven.
        repeat (2) @(negedge clk);
        set_p0(1'b1, 1'b0, 32'h40, 32'h0, 4'hF);
        #1;
        check("rst_p0_ready", p0_rdy[0], 1'b0);
        check("rst_mem_enable", mem_en[0], 1'b0);
        check("rst_mem_address", mem_addr[0], 32'h0);
        check("rst_p0_rsp_valid", p0_rv[0], 1'b0);

        // First cycle after release: p0 read of 0x40 granted (lat2 instance).
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("first_grant_p0_ready", p0_rdy[1], 1'b1);
        check("first_grant_mem_address", mem_addr[1], 32'h40);

        // Reset asserted one cycle later: in-flight reads are dropped.
        @(negedge clk);
        rst = 1'b0;
        idle();
        #1;
        check("midrst_lat1_p0_rsp", p0_rv[0], 1'b0);
        check("midrst_lat2_p0_rsp_a", p0_rv[1], 1'b0);
        check("midrst_mem_enable", mem_en[1], 1'b0);
        @(negedge clk);
        #1;
        check("midrst_lat2_p0_rsp_b", p0_rv[1], 1'b0);
        check("midrst_lat2_p1_rsp_b", p1_rv[1], 1'b0);

        // Release with a p1 read of 0x44 in the same cycle; its data comes 2 cycles later.
        @(negedge clk);
        rst = 1'b1;
        set_p1(1'b1, 1'b0, 32'h44, 32'h0, 4'hF);
        #1;
        check("postrst_p1_ready", p1_rdy[1], 1'b1);
        check("postrst_p0_ready", p0_rdy[1], 1'b0);
        check("postrst_lat3_stale_rsp", p0_rv[2], 1'b0);
        @(negedge clk);
        idle();
        #1;
        check("postrst_p1_rsp_early", p1_rv[1], 1'b0);
        @(negedge clk);
        #1;
        check("postrst_p1_rsp_valid", p1_rv[1], 1'b1);
        check("postrst_p1_rsp_rdata", p1_rd[1], 32'h0BADF00D);
        check("postrst_p0_rsp_valid", p0_rv[1], 1'b0);
        check("postrst_p0_rsp_rdata", p0_rd[1], 32'h0);
        idle_cycles(4);

        // Single read, latency 1.
        @(negedge clk);
        set_p0(1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
        #1;
        check("single_mem_enable", mem_en[0], 1'b1);
        check("single_mem_address", mem_addr[0], 32'h100);
        check("single_mem_we", mem_we[0], 1'b0);
        check("single_p1_ready", p1_rdy[0], 1'b0);
        @(negedge clk);
        idle();
        #1;
        check("single_p0_rsp_valid", p0_rv[0], 1'b1);
        check("single_p0_rsp_rdata", p0_rd[0], 32'h12345678);
        check("single_p1_rsp_valid", p1_rv[0], 1'b0);
        check("idle_mem_enable", mem_en[0], 1'b0);
        check("idle_mem_address", mem_addr[0], 32'h0);
        idle_cycles(4);

        // Reset pulse so the priority state starts at port 0 for the contention run.
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        // Contention for 6 cycles: fixed priority gives all to p0, round-robin alternates.
        prev_p0 = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            set_p0(1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
            set_p1(1'b1, 1'b0, 32'h44, 32'h0, 4'hF);
            #1;
            exp_p0 = RR ? ((i % 2) == 0) : 1'b1;
            check($sformatf("cont%0d_p0_ready", i), p0_rdy[0], exp_p0);
            check($sformatf("cont%0d_p1_ready", i), p1_rdy[0], !exp_p0);
            if (i > 0) begin
                check($sformatf("cont%0d_p0_rsp", i), p0_rv[0], prev_p0);
                check($sformatf("cont%0d_p1_rsp", i), p1_rv[0], !prev_p0);
            end
            prev_p0 = exp_p0;
        end
        @(negedge clk);
        set_p0(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        #1;
        check("cont_drop_p1_ready", p1_rdy[0], 1'b1);
        check("cont_drop_p0_ready", p0_rdy[0], 1'b0);
        check("cont_last_p0_rsp", p0_rv[0], prev_p0);
        @(negedge clk);
        idle();
        #1;
        check("cont_drop_p1_rsp_valid", p1_rv[0], 1'b1);
        check("cont_drop_p1_rsp_rdata", p1_rd[0], 32'h0BADF00D);
        idle_cycles(4);

        // p1 partial write, then p0 reads the merged word back.
        @(negedge clk);
        set_p1(1'b1, 1'b1, 32'h200, 32'hA5A5A5A5, 4'b0011);
        #1;
        check("wr_mem_we", mem_we[0], 1'b1);
        check("wr_mem_be", mem_be[0], 4'b0011);
        check("wr_mem_wdata", mem_wdata[0], 32'hA5A5A5A5);
        check("wr_mem_address", mem_addr[0], 32'h200);
        @(negedge clk);
        idle();
        set_p0(1'b1, 1'b0, 32'h200, 32'h0, 4'hF);
        #1;
        check("wr_no_p1_rsp", p1_rv[0], 1'b0);
        check("wr_no_p0_rsp", p0_rv[0], 1'b0);
        @(negedge clk);
        idle();
        #1;
        check("rd_after_wr_valid", p0_rv[0], 1'b1);
        check("rd_after_wr_rdata", p0_rd[0], 32'hFFFFA5A5);
        idle_cycles(4);

        // Back-to-back reads p0, p1, p0; checked on the latency-3 instance (and lat1 overlap).
        @(negedge clk);
        set_p0(1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
        @(negedge clk);
        idle();
        set_p1(1'b1, 1'b0, 32'h44, 32'h0, 4'hF);
        #1;
        check("b2b_lat1_same_cycle_rsp", p0_rv[0], 1'b1);
        check("b2b_lat1_same_cycle_grant", p1_rdy[0], 1'b1);
        @(negedge clk);
        idle();
        set_p0(1'b1, 1'b0, 32'h204, 32'h0, 4'hF);
        #1;
        check("b2b_lat1_p1_rsp", p1_rv[0], 1'b1);
        check("b2b_lat3_early", p0_rv[2], 1'b0);
        @(negedge clk);
        idle();
        #1;
        check("b2b_lat3_rsp0_valid", p0_rv[2], 1'b1);
        check("b2b_lat3_rsp0_rdata", p0_rd[2], 32'h12345678);
        check("b2b_lat3_rsp0_p1", p1_rv[2], 1'b0);
        @(negedge clk);
        #1;
        check("b2b_lat3_rsp1_valid", p1_rv[2], 1'b1);
        check("b2b_lat3_rsp1_rdata", p1_rd[2], 32'h0BADF00D);
        check("b2b_lat3_rsp1_p0", p0_rv[2], 1'b0);
        @(negedge clk);
        #1;
        check("b2b_lat3_rsp2_valid", p0_rv[2], 1'b1);
        check("b2b_lat3_rsp2_rdata", p0_rd[2], 32'h0000CAFE);
        @(negedge clk);
        #1;
        check("b2b_lat3_done_p0", p0_rv[2], 1'b0);
        check("b2b_lat3_done_p1", p1_rv[2], 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
